// File: rtl/freq_mon_pkg.sv
// Shared types and constants for the frequency monitor gate-time controller.
package freq_mon_pkg;

  // Measurement window sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HOLD  = 3'd2,
    EVAL  = 3'd3,
    CLEAR = 3'd4
  } fm_state_t;

  // Cycles latch_counter_o is held before the latched count is sampled.
  // This covers the register pipeline inside upcounter_latch_re.
  localparam int HOLD_CYCLES = 2;

  // Width of a run counter that must be able to hold the value fail_count.
  function automatic int run_width(input int fail_count);
    return (fail_count < 2) ? 1 : $clog2(fail_count + 1);
  endfunction

endpackage

// File: rtl/freq_mon_range_check.sv
// Window classifier with consecutive-failure run counters and sticky alarms.
// It is updated only on the one-cycle eval strobe from the sequencer.
module freq_mon_range_check
  import freq_mon_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int FAIL_COUNT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 eval_i,
  input  logic                 alarm_clear_i,
  input  logic [BIT_WIDTH-1:0] value_i,
  input  logic [BIT_WIDTH-1:0] min_i,
  input  logic [BIT_WIDTH-1:0] max_i,
  output logic                 out_of_range_o,
  output logic                 alarm_low_o,
  output logic                 alarm_high_o
);

  localparam int               RUN_W   = run_width(FAIL_COUNT);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAIL_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             is_high;
  logic             is_low;
  logic [RUN_W-1:0] low_base;
  logic [RUN_W-1:0] high_base;
  logic [RUN_W-1:0] low_run_q;
  logic [RUN_W-1:0] low_run_d;
  logic [RUN_W-1:0] high_run_q;
  logic [RUN_W-1:0] high_run_d;
  logic             alarm_low_q;
  logic             alarm_low_d;
  logic             alarm_high_q;
  logic             alarm_high_d;
  logic             oor_q;
  logic             oor_d;

  // Classify the sampled count.
  // An all-ones value means the upstream counter saturated, so it is treated as high.
  // High wins over low when the thresholds are inverted.
  always_comb begin
    is_high = (value_i > max_i) || (value_i == {BIT_WIDTH{1'b1}});
    is_low  = !is_high && (value_i < min_i);
  end

  // Next-state logic for the run counters, the alarms and the window classification.
  // A clear in the same cycle as an eval is applied first.
  // The eval then counts on top of the cleared state.
  always_comb begin
    low_base     = alarm_clear_i ? '0 : low_run_q;
    high_base    = alarm_clear_i ? '0 : high_run_q;
    low_run_d    = low_base;
    high_run_d   = high_base;
    alarm_low_d  = alarm_clear_i ? 1'b0 : alarm_low_q;
    alarm_high_d = alarm_clear_i ? 1'b0 : alarm_high_q;
    oor_d        = oor_q;
    if (eval_i) begin
      oor_d = is_low || is_high;
      if (is_high) begin
        high_run_d = (high_base == RUN_MAX) ? RUN_MAX : high_base + RUN_ONE;
        low_run_d  = '0;
      end else if (is_low) begin
        low_run_d  = (low_base == RUN_MAX) ? RUN_MAX : low_base + RUN_ONE;
        high_run_d = '0;
      end else begin
        low_run_d  = '0;
        high_run_d = '0;
      end
      if (low_run_d == RUN_MAX) begin
        alarm_low_d = 1'b1;
      end
      if (high_run_d == RUN_MAX) begin
        alarm_high_d = 1'b1;
      end
    end
  end

  // State registers for the classifier.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      low_run_q    <= '0;
      high_run_q   <= '0;
      alarm_low_q  <= 1'b0;
      alarm_high_q <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      low_run_q    <= low_run_d;
      high_run_q   <= high_run_d;
      alarm_low_q  <= alarm_low_d;
      alarm_high_q <= alarm_high_d;
      oor_q        <= oor_d;
    end
  end

  assign out_of_range_o = oor_q;
  assign alarm_low_o    = alarm_low_q;
  assign alarm_high_o   = alarm_high_q;

endmodule

// File: rtl/freq_monitor_ctrl.sv
// Gate-time controller for upcounter_latch_re.
// It sequences latch/reset of the upstream edge counter, captures the latched count
// once per window, and hands it to the range checker.
//
// Interface protocol:
// - reset_counter_o is high in IDLE/CLEAR and holds the upstream counter at zero.
// - latch_counter_o is high in HOLD/EVAL.
// - measured_valid_o is a one-cycle qualifier with no back-pressure.
//   measured_o, out_of_range_o and the alarms are valid in the cycle it is high.
//   They then stay stable until the next pulse, or until alarm_clear_i for the alarms.
module freq_monitor_ctrl
  import freq_mon_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int GATE_WIDTH = 24,
  parameter int FAIL_COUNT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic [GATE_WIDTH-1:0] gate_cycles_i,
  input  logic [BIT_WIDTH-1:0]  min_count_i,
  input  logic [BIT_WIDTH-1:0]  max_count_i,
  input  logic                  alarm_clear_i,
  input  logic [BIT_WIDTH-1:0]  counter_value_i,
  output logic                  latch_counter_o,
  output logic                  reset_counter_o,
  output logic [BIT_WIDTH-1:0]  measured_o,
  output logic                  measured_valid_o,
  output logic                  out_of_range_o,
  output logic                  alarm_low_o,
  output logic                  alarm_high_o,
  output fm_state_t             state_o
);

  localparam logic [GATE_WIDTH-1:0] TIMER_ONE   = GATE_WIDTH'(1);
  localparam logic [GATE_WIDTH-1:0] HOLD_RELOAD = GATE_WIDTH'(HOLD_CYCLES - 1);

  fm_state_t             state_q;
  fm_state_t             state_d;
  logic [GATE_WIDTH-1:0] timer_q;
  logic [GATE_WIDTH-1:0] timer_d;
  logic [GATE_WIDTH-1:0] gate_reload;
  logic [BIT_WIDTH-1:0]  min_q;
  logic [BIT_WIDTH-1:0]  min_d;
  logic [BIT_WIDTH-1:0]  max_q;
  logic [BIT_WIDTH-1:0]  max_d;
  logic [BIT_WIDTH-1:0]  measured_q;
  logic                  valid_q;
  logic                  eval_stb;

  // Timer preload for a new window.
  // A zero gate length behaves as a one-cycle gate, so the preload is max(G,1)-1.
  always_comb begin
    gate_reload = (gate_cycles_i == '0) ? '0 : gate_cycles_i - TIMER_ONE;
  end

  // Window sequencer.
  // The timer counts COUNT and HOLD durations.
  // Thresholds are frozen at window start.
  // Dropping enable_i outside CLEAR aborts straight to IDLE without an eval.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    min_d    = min_q;
    max_d    = max_q;
    eval_stb = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = COUNT;
          timer_d = gate_reload;
          min_d   = min_count_i;
          max_d   = max_count_i;
        end
      end
      COUNT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = HOLD;
          timer_d = HOLD_RELOAD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      HOLD: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = EVAL;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      EVAL: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          eval_stb = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (enable_i) begin
          state_d = COUNT;
          timer_d = gate_reload;
          min_d   = min_count_i;
          max_d   = max_count_i;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer, timer and threshold snapshot registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  // Capture the latched count on eval and raise the one-cycle valid pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      measured_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= eval_stb;
      if (eval_stb) begin
        measured_q <= counter_value_i;
      end
    end
  end

  freq_mon_range_check #(
    .BIT_WIDTH  (BIT_WIDTH),
    .FAIL_COUNT (FAIL_COUNT)
  ) u_range_check (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .eval_i         (eval_stb),
    .alarm_clear_i  (alarm_clear_i),
    .value_i        (counter_value_i),
    .min_i          (min_q),
    .max_i          (max_q),
    .out_of_range_o (out_of_range_o),
    .alarm_low_o    (alarm_low_o),
    .alarm_high_o   (alarm_high_o)
  );

  // Upstream counter controls decode directly from the state.
  // Reset therefore forces reset_counter_o high immediately.
  always_comb begin
    reset_counter_o = (state_q == IDLE) || (state_q == CLEAR);
    latch_counter_o = (state_q == HOLD) || (state_q == EVAL);
  end

  assign measured_o       = measured_q;
  assign measured_valid_o = valid_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_freq_monitor_ctrl.sv
// Bench for freq_monitor_ctrl.
// A stub drives counter_value_i directly.
// A window-level reference model predicts period, capture, classification and alarms.
module tb_freq_monitor_ctrl;
  import freq_mon_pkg::*;

  localparam int BW = 16;
  localparam int GW = 24;
  localparam int FC = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          enable_i;
  logic [GW-1:0] gate_cycles_i;
  logic [BW-1:0] min_count_i;
  logic [BW-1:0] max_count_i;
  logic          alarm_clear_i;
  logic [BW-1:0] counter_value_i;
  logic          latch_counter_o;
  logic          reset_counter_o;
  logic [BW-1:0] measured_o;
  logic          measured_valid_o;
  logic          out_of_range_o;
  logic          alarm_low_o;
  logic          alarm_high_o;
  fm_state_t     state_o;

  freq_monitor_ctrl #(.BIT_WIDTH(BW), .GATE_WIDTH(GW), .FAIL_COUNT(FC)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .enable_i         (enable_i),
    .gate_cycles_i    (gate_cycles_i),
    .min_count_i      (min_count_i),
    .max_count_i      (max_count_i),
    .alarm_clear_i    (alarm_clear_i),
    .counter_value_i  (counter_value_i),
    .latch_counter_o  (latch_counter_o),
    .reset_counter_o  (reset_counter_o),
    .measured_o       (measured_o),
    .measured_valid_o (measured_valid_o),
    .out_of_range_o   (out_of_range_o),
    .alarm_low_o      (alarm_low_o),
    .alarm_high_o     (alarm_high_o),
    .state_o          (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [BW-1:0] exp_q[$];

  int m_low_run, m_high_run, m_meas;
  bit m_alarm_low, m_alarm_high, m_oor;
  int cur_gate, cur_min, cur_max, cur_val;
  int kind;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_low_run = 0; m_high_run = 0; m_meas = 0;
    m_alarm_low = 0; m_alarm_high = 0; m_oor = 0;
  endtask

  task automatic model_clear();
    m_low_run = 0; m_high_run = 0; m_alarm_low = 0; m_alarm_high = 0;
  endtask

  // One completed window, judged against the thresholds in force when it started.
  task automatic model_window(input bit cleared);
    bit hi, lo;
    if (cleared) model_clear();
    hi = (cur_val > cur_max) || (cur_val == 65535);
    lo = !hi && (cur_val < cur_min);
    m_oor  = hi || lo;
    m_meas = cur_val;
    if (hi) begin
      m_high_run = (m_high_run < FC) ? m_high_run + 1 : FC;
      m_low_run  = 0;
    end else if (lo) begin
      m_low_run  = (m_low_run < FC) ? m_low_run + 1 : FC;
      m_high_run = 0;
    end else begin
      m_low_run = 0; m_high_run = 0;
    end
    if (m_low_run == FC)  m_alarm_low  = 1;
    if (m_high_run == FC) m_alarm_high = 1;
  endtask

  task automatic check_results(input string pfx);
    check_eq({pfx, "_measured"}, measured_o, m_meas);
    check_eq({pfx, "_oor"}, out_of_range_o, m_oor);
    check_eq({pfx, "_alarm_low"}, alarm_low_o, m_alarm_low);
    check_eq({pfx, "_alarm_high"}, alarm_high_o, m_alarm_high);
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge with the DUT in IDLE or CLEAR; that cycle is window cycle 0.
  task automatic start_run(input int g, input int mn, input int mx, input int v);
    cur_gate = g; cur_min = mn; cur_max = mx; cur_val = v;
    gate_cycles_i   = GW'(g);
    min_count_i     = BW'(mn);
    max_count_i     = BW'(mx);
    counter_value_i = BW'(v);
    enable_i        = 1'b1;
  endtask

  task automatic set_val(input int v);
    cur_val = v;
    counter_value_i = BW'(v);
  endtask

  // Runs the current window to its valid pulse.
  // At cycle chg_at the next window's parameters go onto the pins; they must not affect
  // this window. A nonzero clr_at pulses alarm_clear_i in that cycle.
  task automatic run_window(input int ng, input int nmn, input int nmx,
                            input int chg_at, input int clr_at);
    int g, c;
    bit got;
    logic [BW-1:0] exp_v;
    g = (cur_gate == 0) ? 1 : cur_gate;
    exp_q.push_back(BW'(cur_val));
    got = 0;
    c = 0;
    while (!got && c < g + 12) begin
      @(negedge clk_i);
      c++;
      alarm_clear_i = 1'b0;
      if (c == chg_at) begin
        gate_cycles_i = GW'(ng);
        min_count_i   = BW'(nmn);
        max_count_i   = BW'(nmx);
      end
      if (c == clr_at) alarm_clear_i = 1'b1;
      if (measured_valid_o) got = 1;
      else if (c <= g + 3) begin
        check_eq("latch_ctl", latch_counter_o, (c > g));
        check_eq("reset_ctl", reset_counter_o, 1'b0);
      end
    end
    if (!got) begin
      check_eq("valid_timeout", 0, 1);
      exp_q.delete();
    end else begin
      check_eq("period", c, g + 4);
      model_window(clr_at > 0 && clr_at <= g + 3);
      exp_v = exp_q.pop_front();
      check_eq("sb_measured", measured_o, exp_v);
      check_results("win");
      check_eq("clear_reset_ctl", reset_counter_o, 1'b1);
      check_eq("clear_latch_ctl", latch_counter_o, 1'b0);
    end
    cur_gate = ng; cur_min = nmn; cur_max = nmx;
  endtask

  // Drops enable_i at cycle ab_at of the current window.
  // Nothing measured may change afterwards.
  task automatic abort_window(input int ab_at);
    int g, seen;
    g = (cur_gate == 0) ? 1 : cur_gate;
    seen = 0;
    for (int c = 1; c <= ab_at; c++) begin
      @(negedge clk_i);
      if (measured_valid_o) seen++;
    end
    enable_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_reset_ctl", reset_counter_o, 1'b1);
    check_eq("abort_latch_ctl", latch_counter_o, 1'b0);
    for (int i = 0; i < g + 6; i++) begin
      if (measured_valid_o) seen++;
      @(negedge clk_i);
    end
    check_eq("abort_no_valid", seen, 0);
    check_results("abort");
  endtask

  // Called on the valid negedge: leave the run, then confirm the idle controls.
  task automatic stop_run();
    enable_i = 1'b0;
    @(negedge clk_i);
    check_eq("stop_reset_ctl", reset_counter_o, 1'b1);
    check_eq("stop_latch_ctl", latch_counter_o, 1'b0);
    check_eq("stop_valid", measured_valid_o, 1'b0);
  endtask

  task automatic pick_params(output int g, output int mn, output int mx);
    int t;
    g  = $urandom_range(0, 12);
    mn = $urandom_range(1000, 40000);
    mx = mn + $urandom_range(0, 5000);
    if ($urandom_range(0, 7) == 0) begin
      t = mn; mn = mx; mx = t;
    end
  endtask

  function automatic int pick_val(input int mn, input int mx);
    if ($urandom_range(0, 2) == 0) kind = $urandom_range(0, 4);
    case (kind)
      0:       return (mn <= mx) ? $urandom_range(mx, mn) : $urandom_range(65534, 0);
      1:       return mn - 1 - $urandom_range(0, 500);
      2:       return mx + 1 + $urandom_range(0, 500);
      3:       return 65535;
      default: return ($urandom_range(0, 1) == 0) ? mn : mx;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  int low_tbl[8] = '{30, 30, 30, 30, 30, 50, 30, 30};

  initial begin
    int g, mn, mx, v, clr;
    rst_n_i = 1'b0; enable_i = 1'b0; alarm_clear_i = 1'b0;
    gate_cycles_i = '0; min_count_i = '0; max_count_i = '0; counter_value_i = '0;
    kind = 0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_eq("rst_state", state_o, IDLE);
    check_eq("rst_reset_ctl", reset_counter_o, 1'b1);
    check_eq("rst_latch_ctl", latch_counter_o, 1'b0);
    check_eq("rst_valid", measured_valid_o, 1'b0);
    check_results("rst");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Nominal 100-cycle gate, in range: period 104.
    start_run(100, 40, 60, 50);
    run_window(100, 40, 60, 7, 0); set_val(50);
    run_window(100, 40, 60, 50, 0); set_val(50);
    run_window(10, 40, 60, 104, 0); set_val(low_tbl[0]);

    // Low runs: alarm on the third low window; a clear on EVAL restarts the run.
    // A good window breaks the run.
    for (int i = 0; i < 8; i++) begin
      run_window(10, 40, (i == 7) ? 65535 : 60, 3, (i == 3) ? 13 : 0);
      set_val((i < 7) ? low_tbl[i + 1] : 65535);
    end

    // Saturated upstream value is high even when max is all-ones.
    for (int i = 0; i < 3; i++) begin
      run_window(10, 40, 65535, 2, 0);
      set_val(65535);
    end
    stop_run();
    alarm_clear_i = 1'b1;
    @(negedge clk_i);
    alarm_clear_i = 1'b0;
    model_clear();
    check_eq("clr_alarm_low", alarm_low_o, 1'b0);
    check_eq("clr_alarm_high", alarm_high_o, 1'b0);

    // Abort in HOLD with an alarm standing.
    start_run(8, 40, 60, 65535);
    for (int i = 0; i < 3; i++) begin
      run_window(8, 40, 60, 4, 0);
      set_val(65535);
    end
    abort_window(9);

    // Zero gate: 5-cycle period; then an asynchronous reset in EVAL.
    start_run(0, 40, 60, 50);
    for (int i = 0; i < 3; i++) begin
      run_window(0, 40, 60, 1, 0);
      set_val(20 + 30 * i);
    end
    repeat (4) @(negedge clk_i);
    check_eq("pre_rst_latch", latch_counter_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    enable_i = 1'b0;
    model_reset();
    check_eq("mid_rst_reset_ctl", reset_counter_o, 1'b1);
    check_eq("mid_rst_latch_ctl", latch_counter_o, 1'b0);
    check_eq("mid_rst_valid", measured_valid_o, 1'b0);
    check_results("mid_rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Randomized windows with mid-window parameter changes, clears and aborts.
    pick_params(g, mn, mx);
    start_run(g, mn, mx, pick_val(mn, mx));
    for (int i = 0; i < 40; i++) begin
      g = (cur_gate == 0) ? 1 : cur_gate;
      if ($urandom_range(0, 9) == 0) begin
        abort_window($urandom_range(1, g + 3));
        start_run(cur_gate, cur_min, cur_max, cur_val);
      end else begin
        clr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, g + 3) : 0;
        pick_params(v, mn, mx);
        run_window(v, mn, mx, $urandom_range(1, g + 4), clr);
        set_val(pick_val(cur_min, cur_max));
      end
    end
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
